// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - arbitrates core fetch and boot loader access to a byte-wide big-endian instruction store
module imem_port_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [31:0]       f_req_addr,
    output logic              f_rsp_valid,
    input  logic              f_rsp_ready,
    output logic [31:0]       f_rsp_data,
    output logic              f_rsp_err,
    input  logic              l_req_valid,
    output logic              l_req_ready,
    input  logic [31:0]       l_req_addr,
    input  logic [31:0]       l_req_wdata,
    output logic              l_rsp_valid,
    input  logic              l_rsp_ready,
    output logic              l_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic OWN_FETCH  = 1'b0;
    localparam logic OWN_LOADER = 1'b1;

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              own_q, own_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;

    logic              grant_f;
    logic              grant_l;
    logic [31:0]       req_addr;
    logic              addr_bad;
    logic [1:0]        lane;
    logic              in_idle;
    logic              in_resp;
    logic              owner_rsp_ready;

    assign in_idle = (state_q == S_IDLE);
    assign in_resp = (state_q == S_RESP);
    assign lane    = 2'd3 - cnt_q;

    // Round robin: on a contest the requester that did not win last time is granted.
    assign grant_f = !rst && in_idle && f_req_valid && (!l_req_valid || last_q == OWN_LOADER);
    assign grant_l = !rst && in_idle && l_req_valid && (!f_req_valid || last_q == OWN_FETCH);

    assign req_addr = grant_l ? l_req_addr : f_req_addr;
    assign addr_bad = (req_addr[1:0] != 2'b00) || ((req_addr >> ADDR_W) != 32'd0);

    assign owner_rsp_ready = (own_q == OWN_LOADER) ? l_rsp_ready : f_rsp_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        own_d   = own_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_f || grant_l) begin
                    last_d  = grant_l;
                    own_d   = grant_l;
                    base_d  = req_addr[ADDR_W-1:0];
                    wdata_d = grant_l ? l_req_wdata : 32'd0;
                    data_d  = 32'd0;
                    err_d   = addr_bad;
                    cnt_d   = 2'd0;
                    if (addr_bad) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = grant_l ? S_WR : S_RD;
                    end
                end
            end
            S_RD: begin
                data_d[{lane, 3'b000} +: 8] = mem_rdata;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_RESP;
                end
            end
            default: begin
                if (owner_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            last_q  <= OWN_LOADER;
            own_q   <= OWN_FETCH;
            base_q  <= '0;
            wdata_q <= 32'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            own_q   <= own_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign f_req_ready = grant_f;
    assign l_req_ready = grant_l;

    // Response signals only ever face the requester that owns the transaction.
    assign f_rsp_valid = in_resp && (own_q == OWN_FETCH);
    assign f_rsp_err   = f_rsp_valid && err_q;
    assign f_rsp_data  = f_rsp_valid ? data_q : 32'd0;
    assign l_rsp_valid = in_resp && (own_q == OWN_LOADER);
    assign l_rsp_err   = l_rsp_valid && err_q;

    // Write enable is cut during reset so an interrupted word write stops mid-word.
    assign mem_we    = !rst && (state_q == S_WR);
    assign mem_addr  = (state_q == S_RD || state_q == S_WR)
                     ? base_q + {{(ADDR_W-2){1'b0}}, cnt_q} : '0;
    assign mem_wdata = (state_q == S_WR) ? wdata_q[{lane, 3'b000} +: 8] : 8'd0;

    assign busy = !in_idle;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - randomized self-checking bench for imem_port_arbiter
module tb_imem_port_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              f_req_valid = 1'b0;
    logic              f_req_ready;
    logic [31:0]       f_req_addr = 32'd0;
    logic              f_rsp_valid;
    logic              f_rsp_ready = 1'b0;
    logic [31:0]       f_rsp_data;
    logic              f_rsp_err;
    logic              l_req_valid = 1'b0;
    logic              l_req_ready;
    logic [31:0]       l_req_addr = 32'd0;
    logic [31:0]       l_req_wdata = 32'd0;
    logic              l_rsp_valid;
    logic              l_rsp_ready = 1'b0;
    logic              l_rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;

    imem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
        .f_rsp_err(f_rsp_err),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_addr(l_req_addr),
        .l_req_wdata(l_req_wdata), .l_rsp_valid(l_rsp_valid), .l_rsp_ready(l_rsp_ready),
        .l_rsp_err(l_rsp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [4096];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = 12'd0;
    logic [7:0]  pl_data = 8'd0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    logic [31:0] ref_word [1024];
    bit          last_loader;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:12] != 20'd0);
    endfunction

    // Services the given requests to completion; starts and ends at posedge+1 with the DUT idle.
    task automatic run(input bit fv, input logic [31:0] fa, input bit lv, input logic [31:0] la,
                       input logic [31:0] ld, input int hold_f, input int hold_l);
        bit          pf, pl, own, bad;
        logic [31:0] a, exp_data;
        logic [11:0] ea;
        int          hold;
        pf = fv; pl = lv;
        f_req_valid = pf; f_req_addr = fa;
        l_req_valid = pl; l_req_addr = la; l_req_wdata = ld;
        while (pf || pl) begin
            #1;
            check("idle_busy", busy, 0);
            own = (pf && pl) ? !last_loader : pl;
            check("grant", {f_req_ready, l_req_ready}, own ? 2'b01 : 2'b10);
            last_loader = own;
            a = own ? la : fa;
            bad = is_bad(a);
            exp_data = (bad || own) ? 32'd0 : ref_word[a[11:2]];
            tick();
            if (own) begin pl = 0; l_req_valid = 0; end
            else begin pf = 0; f_req_valid = 0; end
            if (!bad) begin
                for (int k = 0; k < 4; k++) begin
                    #1;
                    ea = a[11:0] + 12'(k);
                    check("mem_addr", mem_addr, ea);
                    check("mem_we", mem_we, own);
                    if (own) check("mem_wdata", mem_wdata, (ld >> (8 * (3 - k))) & 32'hFF);
                    check("early_rsp", {f_rsp_valid, l_rsp_valid}, 0);
                    check("ready_busy", {f_req_ready, l_req_ready}, 0);
                    tick();
                end
                if (own) ref_word[a[11:2]] = ld;
            end
            hold = own ? hold_l : hold_f;
            for (int h = 0; h <= hold; h++) begin
                #1;
                check("rsp_valid", {f_rsp_valid, l_rsp_valid}, own ? 2'b01 : 2'b10);
                check("rsp_err", own ? l_rsp_err : f_rsp_err, bad);
                if (!own) check("rsp_data", f_rsp_data, exp_data);
                check("resp_ready", {f_req_ready, l_req_ready}, 0);
                check("resp_we", mem_we, 0);
                if (h == hold) begin
                    if (own) l_rsp_ready = 1; else f_rsp_ready = 1;
                end
                tick();
            end
            f_rsp_ready = 0; l_rsp_ready = 0;
        end
    endtask

    task automatic reset_mid_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] old, got;
        old = ref_word[a[11:2]];
        l_req_valid = 1; l_req_addr = a; l_req_wdata = d;
        #1;
        check("rstw_grant", {f_req_ready, l_req_ready}, 2'b01);
        tick();
        l_req_valid = 0;
        tick();
        tick();
        rst = 1;
        #1;
        check("rstw_we_cut", mem_we, 0);
        tick();
        rst = 0;
        #1;
        check("rstw_busy", busy, 0);
        check("rstw_we", mem_we, 0);
        check("rstw_addr", mem_addr, 0);
        check("rstw_valids", {f_rsp_valid, l_rsp_valid}, 0);
        got = {mem[a[11:0]], mem[a[11:0] + 12'd1], mem[a[11:0] + 12'd2], mem[a[11:0] + 12'd3]};
        ref_word[a[11:2]] = {d[31:16], old[15:0]};
        check("rstw_word", got, ref_word[a[11:2]]);
        last_loader = 1;
        tick();
    endtask

    initial begin
        logic [31:0] val, fa, la, ld;
        int mode;
        rst = 1;
        last_loader = 1;
        #1;
        pl_en = 1;
        for (int w = 0; w < 1024; w++) begin
            val = (w == 0) ? 32'h00900493 : $urandom;
            ref_word[w] = val;
            for (int b = 0; b < 4; b++) begin
                pl_addr = 12'(w * 4 + b);
                pl_data = 8'(val >> (8 * (3 - b)));
                tick();
            end
        end
        pl_en = 0;
        f_req_valid = 1; l_req_valid = 1;
        #1;
        check("reset_ready", {f_req_ready, l_req_ready}, 0);
        check("reset_busy", busy, 0);
        check("reset_mem", {mem_we, 4'(0), mem_addr}, 0);
        tick();
        rst = 0;

        run(1, 32'h000, 1, 32'h040, 32'h11223344, 0, 0);
        run(1, 32'h040, 1, 32'h044, 32'hA5A55A5A, 1, 2);
        run(0, 0, 1, 32'h018, 32'hFE420AE3, 0, 0);
        run(1, 32'h018, 0, 0, 0, 0, 0);
        run(1, 32'h006, 0, 0, 0, 0, 0);
        run(0, 0, 1, 32'h00001000, 32'hDEADBEEF, 0, 0);
        run(1, 32'h018, 1, 32'h030, 32'h0BADF00D, 3, 3);
        reset_mid_write(32'h080, 32'hCAFEF00D);
        run(1, 32'h080, 0, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            mode = $urandom_range(0, 2);
            fa = {20'd0, 12'($urandom_range(0, 1023) * 4)};
            la = {20'd0, 12'($urandom_range(0, 1023) * 4)};
            ld = $urandom;
            if ($urandom_range(0, 7) == 0) fa = fa | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) la = la | 32'h00010000;
            run(mode != 1, fa, mode != 0, la, ld, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
